// File: rtl/pwm_cfg_pkg.sv
// ---------------------------------------------------------------------------
// pwm_cfg_pkg : shared constants, write-entry layout and FSM states.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pwm_cfg_pkg;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;

  localparam int NUM_REGS = 5;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int ENTRY_W  = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

`default_nettype wire

// File: rtl/cfg_write_fifo.sv
// ---------------------------------------------------------------------------
// cfg_write_fifo : power-of-two deep write queue, registered count.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cfg_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/pwm_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// pwm_cfg_scheduler : queued SPI register writes with period-aligned commit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_cfg_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_REGS   = pwm_cfg_pkg::NUM_REGS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit_mode,
  input  logic       period_tick,
  input  logic       clr_err,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       pending,
  output logic       bad_addr
);

  import pwm_cfg_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       shadow_q [NUM_REGS];
  logic [7:0]       shadow_d [NUM_REGS];
  logic [7:0]       active_q [NUM_REGS];
  logic [7:0]       active_d [NUM_REGS];
  logic             pending_q, pending_d;
  logic             bad_addr_q, bad_addr_d;
  state_e           state_q, state_d;

  wr_entry_t        push_entry;
  wr_entry_t        pop_entry;
  logic [ENTRY_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  logic             pop_valid;
  logic             pop_bad;
  logic             pend_raw;
  logic             commit_all;
  logic             nonempty_next;

  assign push_entry = '{addr: wr_addr, data: wr_data};
  assign pop_entry  = wr_entry_t'(fifo_dout);
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && wr_ready;
  assign pop        = (state_q == ST_DRAIN) && !fifo_empty;
  assign pop_valid  = pop && (int'(pop_entry.addr) < NUM_REGS);
  assign pop_bad    = pop && !(int'(pop_entry.addr) < NUM_REGS);

  cfg_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Shadow equals active whenever nothing is pending, so an immediate-mode
  // write is simply a full shadow->active copy on the pop edge.
  assign pend_raw      = pending_q || (pop_valid && commit_mode);
  assign commit_all    = commit_mode ? (period_tick && pend_raw) : 1'b1;
  assign nonempty_next = push || (fifo_count > CNT_W'(1)) ||
                         ((fifo_count == CNT_W'(1)) && !pop);

  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pend_raw;
    bad_addr_d = bad_addr_q;
    state_d    = state_q;

    for (int i = 0; i < NUM_REGS; i++) begin
      if (pop_valid && (pop_entry.addr == 7'(i))) shadow_d[i] = pop_entry.data;
    end

    if (commit_all) begin
      active_d  = shadow_d;
      pending_d = 1'b0;
    end

    if (pop_bad)      bad_addr_d = 1'b1;
    else if (clr_err) bad_addr_d = 1'b0;

    case (state_q)
      ST_IDLE:  if (push) state_d = ST_DRAIN;
      ST_DRAIN: if (!nonempty_next) state_d = pending_d ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (push)           state_d = ST_DRAIN;
        else if (!pending_d) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '{default: 8'h00};
      active_q   <= '{default: 8'h00};
      pending_q  <= 1'b0;
      bad_addr_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      bad_addr_q <= bad_addr_d;
      state_q    <= state_d;
    end
  end

  assign en_reg_out_7_0  = active_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = active_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = active_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = active_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = active_q[ADDR_DUTY];
  assign pending         = pending_q;
  assign bad_addr        = bad_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pwm_cfg_scheduler : scoreboard bench with a queue-based reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_cfg_scheduler;

  localparam int DEPTH = 4;
  localparam int NR    = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit_mode;
  logic       period_tick;
  logic       clr_err;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       pending;
  logic       bad_addr;

  always #5 clk = ~clk;

  pwm_cfg_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .NUM_REGS   (NR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .commit_mode     (commit_mode),
    .period_tick     (period_tick),
    .clr_err         (clr_err),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .pending         (pending),
    .bad_addr        (bad_addr)
  );

  typedef struct packed {
    logic [7:0] r0, r1, r2, r3, r4;
    logic       pend, bad, rdy;
  } snap_t;

  typedef struct {
    int         a;
    logic [7:0] d;
  } wr_t;

  snap_t      sb_q[$];
  wr_t        m_fifo[$];
  logic [7:0] m_shadow[NR];
  logic [7:0] m_active[NR];
  bit         m_pend;
  bit         m_bad;
  bit         last_acc;
  int         checks = 0;
  int         passed = 0;

  // Reference model: the queue holds accepted writes; one leaves per edge.
  function automatic void model_edge();
    bit    acc;
    bit    popped_bad;
    wr_t   e;
    snap_t s;
    acc        = 1'b0;
    popped_bad = 1'b0;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_shadow[i] = 8'h00;
        m_active[i] = 8'h00;
      end
      m_fifo.delete();
      m_pend = 1'b0;
      m_bad  = 1'b0;
    end else begin
      acc = wr_valid && (m_fifo.size() < DEPTH);
      if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        if (e.a < NR) begin
          m_shadow[e.a] = e.d;
          if (commit_mode) m_pend = 1'b1;
          else             m_active[e.a] = e.d;
        end else begin
          popped_bad = 1'b1;
        end
      end
      if (popped_bad)   m_bad = 1'b1;
      else if (clr_err) m_bad = 1'b0;
      if (m_pend && (!commit_mode || period_tick)) begin
        for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
        m_pend = 1'b0;
      end
      if (acc) begin
        e.a = int'(wr_addr);
        e.d = wr_data;
        m_fifo.push_back(e);
      end
    end
    last_acc = acc;
    s.r0   = m_active[0];
    s.r1   = m_active[1];
    s.r2   = m_active[2];
    s.r3   = m_active[3];
    s.r4   = m_active[4];
    s.pend = m_pend;
    s.bad  = m_bad;
    s.rdy  = (m_fifo.size() < DEPTH);
    sb_q.push_back(s);
  endfunction

  // Monitor: every post-edge snapshot the model produced is compared here.
  always @(negedge clk) begin
    snap_t exp_s;
    snap_t act_s;
    if (sb_q.size() > 0) begin
      exp_s = sb_q.pop_front();
      act_s = '{r0: r0, r1: r1, r2: r2, r3: r3, r4: r4,
                pend: pending, bad: bad_addr, rdy: wr_ready};
      checks++;
      if (act_s === exp_s) passed++;
      else $display("FAIL outputs@%0t: got regs=%h_%h_%h_%h_%h pend=%b bad=%b rdy=%b, expected regs=%h_%h_%h_%h_%h pend=%b bad=%b rdy=%b",
                    $time, act_s.r0, act_s.r1, act_s.r2, act_s.r3, act_s.r4, act_s.pend, act_s.bad, act_s.rdy,
                    exp_s.r0, exp_s.r1, exp_s.r2, exp_s.r3, exp_s.r4, exp_s.pend, exp_s.bad, exp_s.rdy);
    end
  end

  task automatic step(input bit v, input logic [6:0] a, input logic [7:0] d,
                      input bit m, input bit t, input bit c, input bit r);
    @(negedge clk);
    wr_valid    = v;
    wr_addr     = a;
    wr_data     = d;
    commit_mode = m;
    period_tick = t;
    clr_err     = c;
    rst         = r;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input bit m, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 7'd0, 8'h00, m, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write(input logic [6:0] a, input logic [7:0] d, input bit m);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      step(1'b1, a, d, m, 1'b0, 1'b0, 1'b0);
      done = last_acc;
    end
    if (!done) begin
      checks++;
      $display("FAIL write_accept: addr %0d never accepted within 16 cycles, required acceptance", a);
    end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit_mode = 1'b0; period_tick = 1'b0; clr_err = 1'b0;

    step(1'b1, 7'd4, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);

    write(7'd4, 8'h80, 1'b0);
    idle(1'b0, 3);

    write(7'd0, 8'hFF, 1'b1);
    write(7'd2, 8'h0F, 1'b1);
    idle(1'b1, 3);
    step(1'b0, 7'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);

    for (int i = 0; i < 5; i++) write(7'(i), 8'(8'h31 + i), 1'b0);
    idle(1'b0, 4);

    write(7'd9, 8'h55, 1'b0);
    idle(1'b0, 2);
    step(1'b1, 7'd9, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1);
    step(1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1);

    write(7'd1, 8'h11, 1'b1);
    write(7'd3, 8'h33, 1'b1);
    step(1'b1, 7'd0, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'd4, 8'h99, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 3);

    write(7'd1, 8'hA5, 1'b1);
    step(1'b0, 7'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);

    write(7'd4, 8'h44, 1'b1);
    idle(1'b1, 2);
    idle(1'b0, 2);

    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 1)),
           7'($urandom_range(0, 9)),
           8'($urandom),
           bit'($urandom_range(0, 4) != 0),
           bit'($urandom_range(0, 7) == 0),
           bit'($urandom_range(0, 15) == 0),
           bit'($urandom_range(0, 63) == 0));
    end
    idle(1'b0, 3);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d snapshots left, required 0", sb_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
